// File: rtl/cofre_pkg.sv
// cofre_pkg -- shared types and constants for the safe alarm controller.
//   cofre_state_t   : FSM state encoding (codes are visible on the lcd debug field)
//   COFRE_MAX_DOORS : upper bound on the number of monitored contacts
package cofre_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    GRACE = 2'd2,
    ALARM = 2'd3
  } cofre_state_t;

  localparam int unsigned COFRE_MAX_DOORS = 8;

endpackage

// File: rtl/cofre_alarm_ctrl_grace_timer.sv
// grace_timer -- CW-bit down-counter used for the pre-alarm grace window.
//   clk_2, reset : clock, asynchronous active-high reset
//   load         : load count with load_val (priority over en)
//   load_val     : value loaded on load
//   en           : decrement by one per cycle, saturating at zero
//   count        : current (registered) count
//   done         : count == 1, i.e. this is the last grace cycle
module grace_timer #(
  parameter int unsigned CW = 3
) (
  input  logic          clk_2,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          done
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == CW'(1));

endmodule

// File: rtl/cofre_alarm_ctrl.sv
// cofre_alarm_ctrl -- sequential safe ("cofre") alarm controller.
// Watches NDOORS contacts against the time-lock window (relogio) and the
// manager key (gerente). An unauthorised opening while armed starts a grace
// countdown; if the manager does not turn up before it expires the alarm
// latches and only an acknowledged manager can clear it.
//   clk_2        : system clock
//   reset        : asynchronous, active-high reset
//   door_open    : per-contact open flags
//   relogio      : business-hours window (disarm allowed)
//   gerente      : manager key present
//   ack          : alarm acknowledge (only with gerente)
//   panic        : (COFRE_PANIC_EN builds only) force ALARM from any state
//   alarme       : 1 while in ALARM
//   pending      : 1 while in GRACE
//   zone_latched : doors seen open since arming
//   state        : current state code (lcd debug)
//   grace_cnt    : remaining grace cycles (lcd debug)
// Optional feature macro: COFRE_PANIC_EN
module cofre_alarm_ctrl
  import cofre_pkg::*;
#(
  parameter int unsigned NDOORS       = 4,
  parameter int unsigned GRACE_CYCLES = 5,
  localparam int unsigned CW = (GRACE_CYCLES == 0) ? 1 : $clog2(GRACE_CYCLES + 1)
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic [NDOORS-1:0] door_open,
  input  logic              relogio,
  input  logic              gerente,
  input  logic              ack,
`ifdef COFRE_PANIC_EN
  input  logic              panic,
`endif
  output logic              alarme,
  output logic              pending,
  output logic [NDOORS-1:0] zone_latched,
  output logic [1:0]        state,
  output logic [CW-1:0]     grace_cnt
);

  cofre_state_t      state_q, state_d;
  logic [NDOORS-1:0] zone_q, zone_d;
  logic              alarme_q, alarme_d;
  logic              pending_q, pending_d;

  logic              tmr_load;
  logic [CW-1:0]     tmr_load_val;
  logic              tmr_en;
  logic              tmr_done;
  logic              intrude;

  assign intrude = |door_open;

  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    case (state_q)
      IDLE: begin
        if (!relogio) state_d = ARMED;
      end
      ARMED: begin
        if (relogio) begin
          state_d = IDLE;
          zone_d  = '0;
        end else if (intrude && !gerente) begin
          zone_d  = zone_q | door_open;
          state_d = (GRACE_CYCLES == 0) ? ALARM : GRACE;
        end
      end
      GRACE: begin
        zone_d = zone_q | door_open;
        // Manager abort beats expiry in the same cycle; relogio only picks
        // the landing state.
        if (gerente) begin
          state_d = relogio ? IDLE : ARMED;
          zone_d  = '0;
        end else if (tmr_done) begin
          state_d = ALARM;
        end
      end
      ALARM: begin
        zone_d = zone_q | door_open;
        if (ack && gerente) begin
          state_d = relogio ? IDLE : ARMED;
          zone_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        zone_d  = '0;
      end
    endcase
`ifdef COFRE_PANIC_EN
    if (panic) begin
      state_d = ALARM;
      zone_d  = zone_q;
    end
`endif
  end

  // Counter is reloaded on every cycle that is not a GRACE->GRACE stay:
  // with GRACE_CYCLES when entering GRACE, with zero otherwise, so it reads
  // zero everywhere outside GRACE and can never wrap.
  always_comb begin
    tmr_load     = (state_d != GRACE) || (state_q != GRACE);
    tmr_load_val = (state_d == GRACE) ? CW'(GRACE_CYCLES) : '0;
    tmr_en       = (state_q == GRACE);
    alarme_d     = (state_d == ALARM);
    pending_d    = (state_d == GRACE);
  end

  grace_timer #(
    .CW (CW)
  ) u_grace_timer (
    .clk_2    (clk_2),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .count    (grace_cnt),
    .done     (tmr_done)
  );

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      zone_q    <= '0;
      alarme_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      zone_q    <= zone_d;
      alarme_q  <= alarme_d;
      pending_q <= pending_d;
    end
  end

  assign alarme       = alarme_q;
  assign pending      = pending_q;
  assign zone_latched = zone_q;
  assign state        = state_q;

endmodule

// File: tb/tb_cofre_alarm_ctrl.sv
module tb_cofre_alarm_ctrl;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] door_open = 4'b0000;
  logic       relogio = 1'b1;
  logic       gerente = 1'b0;
  logic       ack = 1'b0;
`ifdef COFRE_PANIC_EN
  logic       panic = 1'b0;
`endif

  logic       alarme, pending;
  logic [3:0] zone_latched;
  logic [1:0] state;
  logic [2:0] grace_cnt;

  logic       alarme0, pending0;
  logic [3:0] zone_latched0;
  logic [1:0] state0;
  logic [0:0] grace_cnt0;

  always #5 clk_2 = ~clk_2;

  cofre_alarm_ctrl #(.NDOORS(4), .GRACE_CYCLES(5)) u_dut (
    .clk_2(clk_2), .reset(reset), .door_open(door_open), .relogio(relogio),
    .gerente(gerente), .ack(ack),
`ifdef COFRE_PANIC_EN
    .panic(panic),
`endif
    .alarme(alarme), .pending(pending), .zone_latched(zone_latched),
    .state(state), .grace_cnt(grace_cnt)
  );

  cofre_alarm_ctrl #(.NDOORS(4), .GRACE_CYCLES(0)) u_dut0 (
    .clk_2(clk_2), .reset(reset), .door_open(door_open), .relogio(relogio),
    .gerente(gerente), .ack(ack),
`ifdef COFRE_PANIC_EN
    .panic(1'b0),
`endif
    .alarme(alarme0), .pending(pending0), .zone_latched(zone_latched0),
    .state(state0), .grace_cnt(grace_cnt0)
  );

  typedef struct {
    int         sel;
    string      nm;
    logic       pn;
    logic [1:0] st;
    logic       al;
    logic       pe;
    logic [3:0] zl;
    logic [2:0] cnt;
  } exp_t;

  exp_t sbq[$];
  event async_chk;
  int   vectors = 0;
  int   miscompares = 0;

  // Monitor: each negedge shows the outputs produced by the preceding
  // posedge; async_chk is used for checks that happen with no clock edge.
  logic [1:0] a_st;
  logic       a_al, a_pe;
  logic [3:0] a_zl;
  logic [2:0] a_cnt;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_2 or async_chk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        if (e.sel == 0) begin
          a_st = state;  a_al = alarme;  a_pe = pending;
          a_zl = zone_latched;  a_cnt = grace_cnt;
        end else begin
          a_st = state0; a_al = alarme0; a_pe = pending0;
          a_zl = zone_latched0; a_cnt = {2'b00, grace_cnt0};
        end
        vectors++;
        if ({a_st, a_al, a_pe, a_zl, a_cnt} !== {e.st, e.al, e.pe, e.zl, e.cnt}) begin
          miscompares++;
          $display("FAIL %s (dut%0d panic=%0b): got st=%0d al=%0b pe=%0b zl=%b cnt=%0d, exp st=%0d al=%0b pe=%0b zl=%b cnt=%0d",
                   e.nm, e.sel, e.pn, a_st, a_al, a_pe, a_zl, a_cnt,
                   e.st, e.al, e.pe, e.zl, e.cnt);
        end
      end
    end
  end

  // Drive inputs just after a negedge and queue the outputs expected after
  // the following posedge.
  task automatic step(input string nm, input int sel, input logic rst,
                      input logic [3:0] d, input logic rel, input logic ger,
                      input logic ak, input logic pn,
                      input logic [1:0] st, input logic al, input logic pe,
                      input logic [3:0] zl, input logic [2:0] cnt);
    exp_t e;
    @(negedge clk_2);
    #1;
    reset = rst; door_open = d; relogio = rel; gerente = ger; ack = ak;
`ifdef COFRE_PANIC_EN
    panic = pn;
`endif
    e.sel = sel; e.nm = nm; e.pn = pn; e.st = st; e.al = al; e.pe = pe;
    e.zl = zl; e.cnt = cnt;
    sbq.push_back(e);
  endtask

  task automatic s(input string nm, input logic rst, input logic [3:0] d,
                   input logic rel, input logic ger, input logic ak,
                   input logic [1:0] st, input logic al, input logic pe,
                   input logic [3:0] zl, input logic [2:0] cnt);
    step(nm, 0, rst, d, rel, ger, ak, 1'b0, st, al, pe, zl, cnt);
  endtask

  // Raise reset between clock edges and expect every output cleared at once.
  task automatic async_reset_check(input string nm);
    exp_t e;
    @(negedge clk_2);
    #1;
    reset = 1'b1;
    #1;
    e.sel = 0; e.nm = nm; e.pn = 1'b0; e.st = 2'd0; e.al = 1'b0; e.pe = 1'b0;
    e.zl = 4'b0000; e.cnt = 3'd0;
    sbq.push_back(e);
    -> async_chk;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //   name            rst door    rel ger ack   st al pe zl      cnt
    s("reset",          1, 4'b0000, 0, 0, 0,    0, 0, 0, 4'b0000, 0);
    s("arm",            0, 4'b0000, 0, 0, 0,    1, 0, 0, 4'b0000, 0);
    s("armed_hold",     0, 4'b0000, 0, 0, 0,    1, 0, 0, 4'b0000, 0);
    // Unauthorised opening: pending t+1..t+5, alarm at t+6.
    s("intrude",        0, 4'b0010, 0, 0, 0,    2, 0, 1, 4'b0010, 5);
    s("grace4",         0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0010, 4);
    s("grace3",         0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0010, 3);
    s("grace2",         0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0010, 2);
    s("grace1",         0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0010, 1);
    s("alarm",          0, 4'b0000, 0, 0, 0,    3, 1, 0, 4'b0010, 0);
    s("alarm_accum",    0, 4'b0100, 1, 0, 0,    3, 1, 0, 4'b0110, 0);
    s("ack_no_mgr",     0, 4'b0000, 1, 0, 1,    3, 1, 0, 4'b0110, 0);
    s("ack_mgr_idle",   0, 4'b0000, 1, 1, 1,    0, 0, 0, 4'b0000, 0);
    s("idle_doors",     0, 4'b1111, 1, 0, 0,    0, 0, 0, 4'b0000, 0);
    // Authorised opening, then intrusion aborted by the manager.
    s("rearm",          0, 4'b0000, 0, 0, 0,    1, 0, 0, 4'b0000, 0);
    s("authorised",     0, 4'b0001, 0, 1, 0,    1, 0, 0, 4'b0000, 0);
    s("intrude2",       0, 4'b0010, 0, 0, 0,    2, 0, 1, 4'b0010, 5);
    s("g2_4",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0010, 4);
    s("g2_latch",       0, 4'b1000, 0, 0, 0,    2, 0, 1, 4'b1010, 3);
    s("g2_relogio",     0, 4'b0000, 1, 0, 0,    2, 0, 1, 4'b1010, 2);
    s("abort_armed",    0, 4'b0000, 0, 1, 0,    1, 0, 0, 4'b0000, 0);
    // Abort on the last grace cycle beats expiry, lands in IDLE.
    s("intrude3",       0, 4'b0100, 0, 0, 0,    2, 0, 1, 4'b0100, 5);
    s("g3_4",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0100, 4);
    s("g3_3",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0100, 3);
    s("g3_2",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0100, 2);
    s("g3_1",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0100, 1);
    s("abort_last",     0, 4'b0000, 1, 1, 0,    0, 0, 0, 4'b0000, 0);
    // Alarm cleared back to ARMED, then ARMED -> IDLE on relogio.
    s("rearm2",         0, 4'b0000, 0, 0, 0,    1, 0, 0, 4'b0000, 0);
    s("intrude4",       0, 4'b1000, 0, 0, 0,    2, 0, 1, 4'b1000, 5);
    s("g4_4",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b1000, 4);
    s("g4_3",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b1000, 3);
    s("g4_2",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b1000, 2);
    s("g4_1",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b1000, 1);
    s("alarm4",         0, 4'b0000, 0, 0, 0,    3, 1, 0, 4'b1000, 0);
    s("ack_mgr_armed",  0, 4'b0000, 0, 1, 1,    1, 0, 0, 4'b0000, 0);
    s("armed_to_idle",  0, 4'b0000, 1, 0, 0,    0, 0, 0, 4'b0000, 0);
    // Reach ALARM again, then reset asynchronously.
    s("rearm3",         0, 4'b0000, 0, 0, 0,    1, 0, 0, 4'b0000, 0);
    s("intrude5",       0, 4'b0001, 0, 0, 0,    2, 0, 1, 4'b0001, 5);
    s("g5_4",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0001, 4);
    s("g5_3",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0001, 3);
    s("g5_2",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0001, 2);
    s("g5_1",           0, 4'b0000, 0, 0, 0,    2, 0, 1, 4'b0001, 1);
    s("alarm5",         0, 4'b0000, 0, 0, 0,    3, 1, 0, 4'b0001, 0);
    async_reset_check("async_reset_alarm");

    // GRACE_CYCLES=0 instance: alarm the cycle after the opening.
    step("g0_reset",  1, 1, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 4'b0000, 0);
    step("g0_arm",    1, 0, 4'b0000, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 0);
    step("g0_alarm",  1, 0, 4'b0001, 0, 0, 0, 0,  3, 1, 0, 4'b0001, 0);
    step("g0_hold",   1, 0, 4'b0000, 0, 0, 0, 0,  3, 1, 0, 4'b0001, 0);
    step("g0_clear",  1, 0, 4'b0000, 1, 1, 1, 0,  0, 0, 0, 4'b0000, 0);

`ifdef COFRE_PANIC_EN
    step("p_reset",   0, 1, 4'b0000, 1, 0, 0, 0,  0, 0, 0, 4'b0000, 0);
    step("p_idle",    0, 0, 4'b0000, 1, 0, 0, 1,  3, 1, 0, 4'b0000, 0);
    step("p_clear",   0, 0, 4'b0000, 1, 1, 1, 0,  0, 0, 0, 4'b0000, 0);
    step("p_arm",     0, 0, 4'b0000, 0, 0, 0, 0,  1, 0, 0, 4'b0000, 0);
    step("p_intrude", 0, 0, 4'b0100, 0, 0, 0, 0,  2, 0, 1, 4'b0100, 5);
    step("p_grace",   0, 0, 4'b0010, 0, 1, 0, 1,  3, 1, 0, 4'b0100, 0);
    async_reset_check("p_async_reset");
`endif

    @(negedge clk_2);
    @(negedge clk_2);
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, exp 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
